// File: rtl/spi_xfer_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: state encoding,
// default widths and the strobe-counter width helper.
`timescale 1ns/1ps
package spi_xfer_seq_pkg;

  localparam int DIV_SIZE_DEF = 6;
  localparam int DATA_W_DEF   = 8;
  localparam int GAP_HC_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // A SHIFT phase spans 2*DATA_W half-cycle strobes.
  function automatic int cntWidth(input int dataW);
    return $clog2(2 * dataW);
  endfunction

endpackage

// File: rtl/spi_xfer_seq_shreg.sv
// Shift register (MSB-first transmit, LSB-in receive) plus the half-cycle
// strobe counter shared by all sequencer states.
`timescale 1ns/1ps
module spi_shreg
  import spi_xfer_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = cntWidth(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_strobe,
  input  logic              i_shift,
  input  logic              i_miso,
  input  logic              i_cnt_clr,
  input  logic              i_cnt_seed,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [CNT_W-1:0]  r_cnt;

  // Even strobes are leading SCK edges (sample), odd strobes trailing (shift out).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx <= '0;
      r_rx <= '0;
    end else if (i_load) begin
      r_tx <= i_data;
    end else if (i_shift && i_strobe) begin
      if (!r_cnt[0]) r_rx <= {r_rx[DATA_W-2:0], i_miso};
      else           r_tx <= {r_tx[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_cnt <= '0;
    else if (i_cnt_clr) r_cnt <= CNT_W'(i_cnt_seed);
    else if (i_strobe)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_mosi = r_tx[DATA_W-1];
  assign o_rx   = r_rx;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI master transfer sequencer: drives an external clock divider and
// frames CS around one or more back-to-back words.
`timescale 1ns/1ps
module spi_xfer_seq
  import spi_xfer_seq_pkg::*;
#(
  parameter int DIV_SIZE = DIV_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int GAP_HC   = GAP_HC_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [DIV_SIZE-1:0] cfg_div,
  input  logic                cfg_div_exp,
  input  logic                cfg_cpol,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                req_last,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                div_clk_en,
  output logic                div_clk_run,
  output logic                div_clk_tog,
  output logic                div_clk_pol,
  output logic                div_exp,
  output logic [DIV_SIZE-1:0] div,
  input  logic                div_hlf_cyc,
  output logic                spi_csn,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                busy
);

  localparam int CNT_W = cntWidth(DATA_W);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_HC - 1);

  state_t              r_state;
  logic                r_acc;
  logic                r_alive;
  logic [DIV_SIZE-1:0] r_div;
  logic                r_divExp;
  logic                r_last;
  logic                r_rspValid;
  logic [DATA_W-1:0]   r_rspData;

  state_t              w_nextState;
  logic                w_nextAcc;
  logic                w_load;
  logic                w_cntClr;
  logic                w_cntSeed;
  logic                w_shifting;
  logic                w_mosi;
  logic [DATA_W-1:0]   w_rx;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_shiftDone;
  logic                w_gapDone;

  assign w_shifting  = (r_state == ST_SHIFT) && !r_acc;
  assign w_shiftDone = div_hlf_cyc && (w_cnt == LAST_SHIFT);
  assign w_gapDone   = div_hlf_cyc && (w_cnt == LAST_GAP);

  spi_shreg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shreg (
    .i_clk      (clk_in),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_data     (req_data),
    .i_strobe   (div_hlf_cyc),
    .i_shift    (w_shifting),
    .i_miso     (spi_miso),
    .i_cnt_clr  (w_cntClr),
    .i_cnt_seed (w_cntSeed),
    .o_mosi     (w_mosi),
    .o_rx       (w_rx),
    .o_cnt      (w_cnt)
  );

  // r_acc marks the single accept cycle between words; CS stays low and
  // SCK is frozen. Transitions not caused by a strobe hand any coincident
  // strobe to the new state through the counter seed.
  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = 1'b0;
    w_load      = 1'b0;
    w_cntSeed   = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = r_alive;
        w_cntSeed = div_hlf_cyc;
        if (req_valid && r_alive) begin
          w_load      = 1'b1;
          w_nextState = ST_SETUP;
        end
      end
      ST_SETUP: if (w_gapDone) w_nextState = ST_SHIFT;
      ST_SHIFT: begin
        if (r_acc) begin
          req_ready = 1'b1;
          w_cntSeed = div_hlf_cyc;
          if (req_valid) begin
            w_load      = 1'b1;
            w_nextState = ST_SETUP;
          end else begin
            w_nextState = ST_HOLD;
          end
        end else if (w_shiftDone) begin
          if (r_last) w_nextState = ST_HOLD;
          else        w_nextAcc   = 1'b1;
        end
      end
      ST_HOLD: if (w_gapDone) w_nextState = ST_GAP;
      ST_GAP:  if (w_gapDone) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    w_cntClr = (w_nextState != r_state) || (w_nextAcc != r_acc);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_nextAcc;
      r_alive <= 1'b1;
    end
  end

  // Shadow copies keep the divider configuration stable for a whole word.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= DIV_SIZE'(1);
      r_divExp <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_load) begin
      r_div    <= cfg_div;
      r_divExp <= cfg_div_exp;
      r_last   <= req_last;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
    end else begin
      r_rspValid <= w_shifting && w_shiftDone;
      if (w_shifting && w_shiftDone) r_rspData <= w_rx;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign div_clk_en  = busy;
  assign div_clk_run = busy;
  assign div_clk_tog = w_shifting;
  assign div_clk_pol = cfg_cpol;
  assign div         = r_div;
  assign div_exp     = r_divExp;
  assign spi_csn     = (r_state == ST_IDLE) || (r_state == ST_GAP);
  assign spi_mosi    = w_mosi;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: plays the clock divider, models SCK from the
// divider controls and compares received/sent words and CS framing.
`timescale 1ns/1ps
module tb_spi_xfer_seq;
  import spi_xfer_seq_pkg::*;

  localparam int DW = 8;
  localparam int DS = 6;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [DS-1:0] cfg_div = '0;
  logic          cfg_div_exp = 1'b0;
  logic          cfg_cpol = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic          req_last = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          div_clk_en, div_clk_run, div_clk_tog, div_clk_pol;
  logic          div_exp;
  logic [DS-1:0] div;
  logic          div_hlf_cyc = 1'b0;
  logic          spi_csn, spi_mosi;
  logic          spi_miso = 1'b0;
  logic          busy;

  spi_xfer_seq #(.DIV_SIZE(DS), .DATA_W(DW), .GAP_HC(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_div_exp(cfg_div_exp),
    .cfg_cpol(cfg_cpol), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .div_clk_en(div_clk_en), .div_clk_run(div_clk_run),
    .div_clk_tog(div_clk_tog), .div_clk_pol(div_clk_pol), .div_exp(div_exp),
    .div(div), .div_hlf_cyc(div_hlf_cyc), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int compared = 0;
  int mismatched = 0;

  // Monitor state: SCK model, edge/strobe counters and captured words.
  bit            sck = 1'b0;
  bit            loopback = 1'b0;
  bit            prevCsn = 1'b1;
  int            strobeRate = 0;
  int            sckPulses, csStrobes, shiftStrobes, readyBusy;
  int            sckIdleErr, csRises, leadTotal, rspCount;
  logic [DW-1:0] txShift;
  logic [DW-1:0] rspQ[$];
  logic [DW-1:0] txQ[$];
  logic [DW-1:0] misoQ[$];
  logic [DW-1:0] sendQ[$];
  logic [DW-1:0] expQ[$];
  logic          sStrobe = 1'b0, sTog = 1'b0, sEn = 1'b0, sMosi = 1'b0, sCsn = 1'b1;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] miso;
    bit            loop;
    logic [DS-1:0] divSel;
    logic          divExp;
    logic          cpol;
    logic          last;
    int            rate;
    logic [DW-1:0] expRsp;
    int            expPulses;
    int            expCs;
    int            expReadyBusy;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Values snapshotted #1 after an edge are what the DUT sees at the next edge.
  initial begin : monitor
    forever begin
      @(posedge clk_in);
      if (!rst_n) begin
        sck = cfg_cpol;
      end else begin
        if (sEn && sStrobe && !sCsn) csStrobes++;
        if (sEn && sStrobe && sTog) begin
          shiftStrobes++;
          if (sck == cfg_cpol) begin
            sckPulses++;
            txShift = {txShift[DW-2:0], sMosi};
            leadTotal++;
            if (leadTotal % DW == 0) txQ.push_back(txShift);
          end
          sck = ~sck;
        end
        if (!sEn) sck = cfg_cpol;
      end
      #1;
      if (rst_n && rsp_valid) begin
        rspCount++;
        rspQ.push_back(rsp_data);
      end
      if (rst_n && busy && req_ready) readyBusy++;
      if (spi_csn && (sck != cfg_cpol)) sckIdleErr++;
      if (spi_csn && !prevCsn) csRises++;
      prevCsn = spi_csn;
      div_hlf_cyc = div_clk_en && ((strobeRate == 0) || ($urandom_range(0, strobeRate) == 0));
      if (loopback) spi_miso = spi_mosi;
      else if (leadTotal / DW < misoQ.size()) spi_miso = misoQ[leadTotal / DW][DW - 1 - (leadTotal % DW)];
      else spi_miso = 1'b0;
      sStrobe = div_hlf_cyc;
      sTog    = div_clk_tog;
      sEn     = div_clk_en;
      sMosi   = spi_mosi;
      sCsn    = spi_csn;
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearMonitor();
    sckPulses = 0; csStrobes = 0; shiftStrobes = 0; readyBusy = 0;
    sckIdleErr = 0; csRises = 0; leadTotal = 0; rspCount = 0; txShift = '0;
    rspQ.delete(); txQ.delete(); misoQ.delete(); sendQ.delete(); expQ.delete();
  endtask

  // Presents one word and returns at the negedge after the handshake.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1;
    req_data  = data;
    req_last  = last;
    for (int i = 0; i < 600; i++) begin
      if (req_ready) begin
        @(negedge clk_in);
        req_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      @(negedge clk_in);
    end
    req_valid = 1'b0;
    checkOutput("reqAcceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      if (!busy) return;
      @(negedge clk_in);
    end
    checkOutput("idleTimeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic runSequence(input logic finalLast);
    bit ok;
    for (int i = 0; i < sendQ.size(); i++) begin
      applyStimulus(sendQ[i], (i == sendQ.size() - 1) ? finalLast : 1'b0, ok);
      if (!ok) break;
    end
    waitIdle(3000);
    @(negedge clk_in);
  endtask

  task automatic checkSequence(input string tag, input int expPulses, input int expCs,
                               input int expRb, input logic [DS-1:0] expDiv, input logic expDivExp);
    checkOutput({tag, ".rspCount"}, rspCount, expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("%s.rsp%0d", tag, i), (i < rspQ.size()) ? {24'd0, rspQ[i]} : 32'hDEAD, {24'd0, expQ[i]});
      checkOutput($sformatf("%s.mosi%0d", tag, i), (i < txQ.size()) ? {24'd0, txQ[i]} : 32'hDEAD, {24'd0, sendQ[i]});
    end
    checkOutput({tag, ".sckPulses"}, sckPulses, expPulses);
    checkOutput({tag, ".csLowStrobes"}, csStrobes, expCs);
    checkOutput({tag, ".readyWhileBusy"}, readyBusy, expRb);
    checkOutput({tag, ".csRises"}, csRises, 1);
    checkOutput({tag, ".sckIdleLevel"}, sckIdleErr, 0);
    checkOutput({tag, ".div"}, {26'd0, div}, {26'd0, expDiv});
    checkOutput({tag, ".divExp"}, {31'd0, div_exp}, {31'd0, expDivExp});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".csn"}, {31'd0, spi_csn}, 32'd1);
    checkOutput({tag, ".mosi"}, {31'd0, spi_mosi}, 32'd0);
    checkOutput({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
    checkOutput({tag, ".rspValid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, ".rspData"}, {24'd0, rsp_data}, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".clkEnRunTog"}, {29'd0, div_clk_en, div_clk_run, div_clk_tog}, 32'd0);
    checkOutput({tag, ".div"}, {26'd0, div}, 32'd1);
    checkOutput({tag, ".divExp"}, {31'd0, div_exp}, 32'd0);
  endtask

  task automatic releaseReset(input string tag);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;
    checkOutput({tag, ".readyBeforeClk"}, {31'd0, req_ready}, 32'd0);
    @(posedge clk_in);
    #1;
    checkOutput({tag, ".readyAfterClk"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk_in);
  endtask

  initial begin : stimulus
    bit ok;
    int n;
    logic finalLast;
    logic [DS-1:0] keepDiv;
    logic keepExp;

    vecs[0] = '{8'hA5, 8'h00, 1'b1, 6'b111100, 1'b0, 1'b0, 1'b1, 0, 8'hA5, 8, 20, 0};
    vecs[1] = '{8'h5A, 8'h3C, 1'b0, 6'h05, 1'b1, 1'b0, 1'b1, 2, 8'h3C, 8, 20, 0};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 6'h2A, 1'b0, 1'b1, 1'b1, 1, 8'h00, 8, 20, 0};
    vecs[3] = '{8'h00, 8'hFF, 1'b0, 6'h01, 1'b1, 1'b1, 1'b0, 0, 8'hFF, 8, 20, 1};
    vecs[4] = '{8'h81, 8'h7E, 1'b0, 6'h3F, 1'b0, 1'b0, 1'b0, 3, 8'h7E, 8, 20, 1};

    clearMonitor();
    repeat (3) @(negedge clk_in);
    checkResetOutputs("reset");
    releaseReset("resetRelease");

    // Idle with inverted polarity: divider follows cfg_cpol, never toggles.
    cfg_cpol = 1'b1;
    @(negedge clk_in);
    checkOutput("idlePol", {31'd0, div_clk_pol}, 32'd1);
    checkOutput("idleTog", {31'd0, div_clk_tog}, 32'd0);
    cfg_cpol = 1'b0;
    @(negedge clk_in);

    foreach (vecs[v]) begin
      clearMonitor();
      cfg_div     = vecs[v].divSel;
      cfg_div_exp = vecs[v].divExp;
      cfg_cpol    = vecs[v].cpol;
      loopback    = vecs[v].loop;
      strobeRate  = vecs[v].rate;
      @(negedge clk_in);
      sendQ.push_back(vecs[v].data);
      misoQ.push_back(vecs[v].miso);
      expQ.push_back(vecs[v].expRsp);
      runSequence(vecs[v].last);
      checkSequence($sformatf("vec%0d", v), vecs[v].expPulses, vecs[v].expCs,
                    vecs[v].expReadyBusy, vecs[v].divSel, vecs[v].divExp);
      checkOutput($sformatf("vec%0d.polFollows", v), {31'd0, div_clk_pol}, {31'd0, vecs[v].cpol});
    end

    // Back-to-back words with loopback: CS must stay low across both.
    clearMonitor();
    cfg_div = 6'b111100; cfg_div_exp = 1'b0; cfg_cpol = 1'b0;
    loopback = 1'b1; strobeRate = 0;
    @(negedge clk_in);
    sendQ.push_back(8'h3C); sendQ.push_back(8'hC3);
    expQ.push_back(8'h3C);  expQ.push_back(8'hC3);
    runSequence(1'b1);
    checkSequence("b2b", 16, 38, 1, 6'b111100, 1'b0);

    // Divider select changed mid-word must not reach the div outputs.
    clearMonitor();
    loopback = 1'b1; strobeRate = 1;
    cfg_div = 6'h11; cfg_div_exp = 1'b1;
    @(negedge clk_in);
    applyStimulus(8'h96, 1'b1, ok);
    for (int i = 0; i < 400 && !div_clk_tog; i++) @(negedge clk_in);
    cfg_div = 6'h22; cfg_div_exp = 1'b0;
    @(negedge clk_in);
    checkOutput("cfgMidShift.div", {26'd0, div}, 32'h11);
    checkOutput("cfgMidShift.divExp", {31'd0, div_exp}, 32'd1);
    waitIdle(3000);
    checkOutput("cfgAfterIdle.div", {26'd0, div}, 32'h11);
    applyStimulus(8'h69, 1'b1, ok);
    checkOutput("cfgNextReq.div", {26'd0, div}, 32'h22);
    checkOutput("cfgNextReq.divExp", {31'd0, div_exp}, 32'd0);
    waitIdle(3000);
    checkOutput("cfgSeq.rspCount", rspCount, 2);

    // Reset asserted just before SHIFT strobe 7 aborts the word.
    clearMonitor();
    loopback = 1'b0; strobeRate = 2;
    misoQ.push_back(8'hF0);
    @(negedge clk_in);
    applyStimulus(8'h5A, 1'b1, ok);
    for (int i = 0; i < 600 && shiftStrobes < 7; i++) @(negedge clk_in);
    checkOutput("abort.reachedStrobe7", shiftStrobes, 7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort.csnAsync", {31'd0, spi_csn}, 32'd1);
    checkOutput("abort.clkEnAsync", {31'd0, div_clk_en}, 32'd0);
    repeat (3) @(negedge clk_in);
    checkResetOutputs("abortReset");
    releaseReset("abortRelease");
    repeat (40) @(negedge clk_in);
    checkOutput("abort.noRsp", rspCount, 0);
    checkOutput("abort.stillIdle", {31'd0, busy}, 32'd0);

    // Randomized multi-word sequences against the transfer-level model.
    for (int t = 0; t < 14; t++) begin
      clearMonitor();
      n = $urandom_range(1, 3);
      finalLast = 1'($urandom_range(0, 1));
      keepDiv = DS'($urandom);
      keepExp = 1'($urandom_range(0, 1));
      cfg_div = keepDiv; cfg_div_exp = keepExp;
      cfg_cpol = 1'($urandom_range(0, 1));
      loopback = 1'b0;
      strobeRate = $urandom_range(0, 3);
      @(negedge clk_in);
      for (int w = 0; w < n; w++) begin
        sendQ.push_back(DW'($urandom));
        misoQ.push_back(DW'($urandom));
        expQ.push_back(misoQ[w]);
      end
      runSequence(finalLast);
      checkSequence($sformatf("rand%0d", t), DW * n, 18 * n + 2,
                    (n - 1) + (finalLast ? 0 : 1), keepDiv, keepExp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
